// File: rtl/regfile_pkg.sv
// Shared defaults and writeback source encoding for the register-file writeback controller.
// Optional forwarding outputs are enabled with the REGFILE_WB_BYPASS_EN macro.
package regfile_pkg;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_ADDR_WIDTH   = 5;
    localparam int DEF_REGFILE_SIZE = 32;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

    function automatic wb_src_e other_src(input wb_src_e s);
        return (s == SRC_ALU) ? SRC_MEM : SRC_ALU;
    endfunction

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Issue, writeback, register-file write and hazard-query signals of regfile_wb_ctrl.
// Used by the default build and by the REGFILE_WB_BYPASS_EN build alike.
interface regfile_wb_ctrl_if
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    // A transfer happens on a rising edge where valid and ready are both 1;
    // ready may depend combinationally on valid, valid must not depend on ready.
    logic                  iss_valid;
    logic [ADDR_WIDTH-1:0] iss_addr;
    logic                  iss_ready;

    logic                  alu_valid;
    logic [ADDR_WIDTH-1:0] alu_addr;
    logic [DATA_WIDTH-1:0] alu_data;
    logic                  alu_ready;

    logic                  mem_valid;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_ready;

    logic                  wrd;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] d;

    logic [ADDR_WIDTH-1:0] rs_a;
    logic [ADDR_WIDTH-1:0] rs_b;
    logic                  hazard_a;
    logic                  hazard_b;

    modport master (
        output iss_valid, iss_addr, alu_valid, alu_addr, alu_data,
               mem_valid, mem_addr, mem_data, rs_a, rs_b,
        input  iss_ready, alu_ready, mem_ready, wrd, addr_d, d, hazard_a, hazard_b
    );

    modport slave (
        input  iss_valid, iss_addr, alu_valid, alu_addr, alu_data,
               mem_valid, mem_addr, mem_data, rs_a, rs_b,
        output iss_ready, alu_ready, mem_ready, wrd, addr_d, d, hazard_a, hazard_b
    );

endinterface

// File: rtl/wb_rr_arbiter.sv
// Two-requester round-robin arbiter choosing between ALU and load writebacks.
// Independent of REGFILE_WB_BYPASS_EN.
module wb_rr_arbiter
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_alu,
    input  logic req_mem,
    output logic gnt_alu,
    output logic gnt_mem
);

    wb_src_e ptr_q, ptr_d;

    // The pointer only moves on contention, so a lone requester never steals the next turn.
    always_comb begin
        gnt_alu = 1'b0;
        gnt_mem = 1'b0;
        ptr_d   = ptr_q;
        if (req_alu && req_mem) begin
            gnt_alu = (ptr_q == SRC_ALU);
            gnt_mem = (ptr_q == SRC_MEM);
            ptr_d   = other_src(ptr_q);
        end else begin
            gnt_alu = req_alu;
            gnt_mem = req_mem;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= SRC_MEM;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: arbitrates ALU/load writebacks onto the register-file write port and
// tracks per-register pending writes for hazard detection. REGFILE_WB_BYPASS_EN adds forwarding.
module regfile_wb_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int REGFILE_SIZE = DEF_REGFILE_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_wb_ctrl_if.slave      bus,
`ifdef REGFILE_WB_BYPASS_EN
    output logic                  fwd_a_valid,
    output logic                  fwd_b_valid,
    output logic [DATA_WIDTH-1:0] fwd_a,
    output logic [DATA_WIDTH-1:0] fwd_b,
`endif
    output logic                  wb_err
);

    logic                  gnt_alu, gnt_mem;
    logic                  issue;
    logic                  wrd_q, wrd_d;
    logic [ADDR_WIDTH-1:0] addr_d_q, addr_d_d;
    logic [DATA_WIDTH-1:0] d_q, d_d;
    logic                  wb_err_q, wb_err_d;
    logic [1:0]            cnt_q [REGFILE_SIZE];
    logic [1:0]            cnt_d [REGFILE_SIZE];
    logic [1:0]            cnt_iss, cnt_rs_a, cnt_rs_b;

    // Requests are masked in reset so neither ready can rise while rst_n is low.
    wb_rr_arbiter u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_alu (bus.alu_valid & rst_n),
        .req_mem (bus.mem_valid & rst_n),
        .gnt_alu (gnt_alu),
        .gnt_mem (gnt_mem)
    );

    always_comb begin
        cnt_iss  = '0;
        cnt_rs_a = '0;
        cnt_rs_b = '0;
        for (int i = 0; i < REGFILE_SIZE; i++) begin
            if (bus.iss_addr == ADDR_WIDTH'(i)) cnt_iss  = cnt_q[i];
            if (bus.rs_a     == ADDR_WIDTH'(i)) cnt_rs_a = cnt_q[i];
            if (bus.rs_b     == ADDR_WIDTH'(i)) cnt_rs_b = cnt_q[i];
        end
    end

    assign bus.iss_ready = (cnt_iss != 2'd3);
    assign issue         = bus.iss_valid && bus.iss_ready;
    assign bus.alu_ready = gnt_alu;
    assign bus.mem_ready = gnt_mem;

    always_comb begin
        wrd_d    = gnt_alu || gnt_mem;
        addr_d_d = addr_d_q;
        d_d      = d_q;
        if (gnt_mem) begin
            addr_d_d = bus.mem_addr;
            d_d      = bus.mem_data;
        end else if (gnt_alu) begin
            addr_d_d = bus.alu_addr;
            d_d      = bus.alu_data;
        end
    end

    // Issue and retire on the same register cancel; retiring an idle register is an error.
    always_comb begin
        wb_err_d = wb_err_q;
        for (int i = 0; i < REGFILE_SIZE; i++) begin
            cnt_d[i] = cnt_q[i];
            if (issue && (bus.iss_addr == ADDR_WIDTH'(i))
                && !(wrd_q && (addr_d_q == ADDR_WIDTH'(i)))) begin
                cnt_d[i] = cnt_q[i] + 2'd1;
            end else if (wrd_q && (addr_d_q == ADDR_WIDTH'(i))
                && !(issue && (bus.iss_addr == ADDR_WIDTH'(i)))) begin
                if (cnt_q[i] == 2'd0) begin
                    wb_err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrd_q    <= 1'b0;
            addr_d_q <= '0;
            d_q      <= '0;
            wb_err_q <= 1'b0;
            for (int i = 0; i < REGFILE_SIZE; i++) cnt_q[i] <= '0;
        end else begin
            wrd_q    <= wrd_d;
            addr_d_q <= addr_d_d;
            d_q      <= d_d;
            wb_err_q <= wb_err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.wrd    = wrd_q;
    assign bus.addr_d = addr_d_q;
    assign bus.d      = d_q;
    assign wb_err     = wb_err_q;

`ifdef REGFILE_WB_BYPASS_EN
    // Forward only the last outstanding write; older pending writes still stall.
    assign fwd_a_valid  = wrd_q && (addr_d_q == bus.rs_a) && (cnt_rs_a == 2'd1);
    assign fwd_b_valid  = wrd_q && (addr_d_q == bus.rs_b) && (cnt_rs_b == 2'd1);
    assign fwd_a        = d_q;
    assign fwd_b        = d_q;
    assign bus.hazard_a = (cnt_rs_a != 2'd0) && !fwd_a_valid;
    assign bus.hazard_b = (cnt_rs_b != 2'd0) && !fwd_b_valid;
`else
    assign bus.hazard_a = (cnt_rs_a != 2'd0);
    assign bus.hazard_b = (cnt_rs_b != 2'd0);
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: directed vector table, reset corner sequences and a randomized
// run against a queue-based reference model. Covers the REGFILE_WB_BYPASS_EN build when defined.
module tb_regfile_wb_ctrl;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wb_err;
`ifdef REGFILE_WB_BYPASS_EN
    logic          fwd_a_valid, fwd_b_valid;
    logic [DW-1:0] fwd_a, fwd_b;
`endif

    regfile_wb_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    regfile_wb_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REGFILE_SIZE(NREG)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
`ifdef REGFILE_WB_BYPASS_EN
        .fwd_a_valid (fwd_a_valid),
        .fwd_b_valid (fwd_b_valid),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
`endif
        .wb_err      (wb_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: pending-write counts per register, writebacks in flight as a queue
    logic [AW+DW-1:0] exp_q[$];
    int               m_cnt[NREG];
    bit               m_err;
    int               m_prio;
    logic [AW-1:0]    m_last_ad;
    logic [DW-1:0]    m_last_d;

    typedef struct {
        bit rst;
        bit iv; int ia;
        bit av; int aa; logic [31:0] ad;
        bit mv; int ma; logic [31:0] md;
        int rsa;
        bit e_ir; bit e_ar; bit e_mr; bit e_ha; bit e_wrd; int e_addr; logic [31:0] e_d; bit e_err;
    } vec_t;
    vec_t vt[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
        exp_q.delete();
        m_err     = 1'b0;
        m_prio    = 1;
        m_last_ad = '0;
        m_last_d  = '0;
    endfunction

    // driver tasks
    task automatic idle_inputs();
        bus.iss_valid = 1'b0; bus.iss_addr = '0;
        bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
        bus.rs_a = '0; bus.rs_b = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic model_check();
        bit ga, gm, fa, fb;
        ga = bus.alu_valid && (!bus.mem_valid || m_prio == 0);
        gm = bus.mem_valid && (!bus.alu_valid || m_prio == 1);
        chk("alu_ready", bus.alu_ready, ga);
        chk("mem_ready", bus.mem_ready, gm);
        chk("iss_ready", bus.iss_ready, m_cnt[bus.iss_addr] != 3);
        fa = BYP && exp_q.size() > 0 && exp_q[0][AW+DW-1:DW] == bus.rs_a && m_cnt[bus.rs_a] == 1;
        fb = BYP && exp_q.size() > 0 && exp_q[0][AW+DW-1:DW] == bus.rs_b && m_cnt[bus.rs_b] == 1;
        chk("hazard_a", bus.hazard_a, m_cnt[bus.rs_a] != 0 && !fa);
        chk("hazard_b", bus.hazard_b, m_cnt[bus.rs_b] != 0 && !fb);
        if (exp_q.size() > 0) begin
            chk("wrd", bus.wrd, 1);
            chk("addr_d", bus.addr_d, exp_q[0][AW+DW-1:DW]);
            chk("d", bus.d, exp_q[0][DW-1:0]);
        end else begin
            chk("wrd", bus.wrd, 0);
            chk("addr_d hold", bus.addr_d, m_last_ad);
            chk("d hold", bus.d, m_last_d);
        end
        chk("wb_err", wb_err, m_err);
`ifdef REGFILE_WB_BYPASS_EN
        chk("fwd_a_valid", fwd_a_valid, fa);
        chk("fwd_b_valid", fwd_b_valid, fb);
        if (fa) chk("fwd_a", fwd_a, exp_q[0][DW-1:0]);
        if (fb) chk("fwd_b", fwd_b, exp_q[0][DW-1:0]);
`endif
    endtask

    task automatic model_step();
        bit ga, gm, issue, ret;
        int ia, ra;
        ga    = bus.alu_valid && (!bus.mem_valid || m_prio == 0);
        gm    = bus.mem_valid && (!bus.alu_valid || m_prio == 1);
        ia    = int'(bus.iss_addr);
        issue = bus.iss_valid && m_cnt[ia] != 3;
        ret   = exp_q.size() > 0;
        ra    = 0;
        if (ret) begin
            ra        = int'(exp_q[0][AW+DW-1:DW]);
            m_last_ad = exp_q[0][AW+DW-1:DW];
            m_last_d  = exp_q[0][DW-1:0];
            void'(exp_q.pop_front());
        end
        if (!(issue && ret && ia == ra)) begin
            if (issue) m_cnt[ia]++;
            if (ret) begin
                if (m_cnt[ra] == 0) m_err = 1'b1;
                else m_cnt[ra]--;
            end
        end
        if (ga) exp_q.push_back({bus.alu_addr, bus.alu_data});
        else if (gm) exp_q.push_back({bus.mem_addr, bus.mem_data});
        if (bus.alu_valid && bus.mem_valid) m_prio = 1 - m_prio;
    endtask

    task automatic cycle();
        @(negedge clk);
        model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        string s;
        idle_inputs();
        m_reset();

        // rst iv ia  av aa ad            mv ma md          rsa  ir ar mr ha    wrd addr d             err
        vt.push_back('{1, 1,3,  0,0,0,            0,0,0,            3,  1,0,0,0,    0,0,0,            0});
        vt.push_back('{0, 0,0,  1,3,32'h0960_1050,0,0,0,            3,  1,1,0,1,    0,0,0,            0});
        vt.push_back('{0, 0,0,  0,0,0,            0,0,0,            3,  1,0,0,!BYP, 1,3,32'h0960_1050,0});
        vt.push_back('{0, 0,0,  0,0,0,            0,0,0,            3,  1,0,0,0,    0,3,32'h0960_1050,0});
        vt.push_back('{1, 0,0,  1,4,32'h0000_a4a4,1,5,32'h0000_5b5b,0,  1,0,1,0,    0,0,0,            0});
        vt.push_back('{0, 0,0,  1,4,32'h0000_a4a4,1,5,32'h0000_5b5b,0,  1,1,0,0,    1,5,32'h0000_5b5b,0});
        vt.push_back('{0, 0,0,  1,4,32'h0000_a4a4,1,5,32'h0000_5b5b,0,  1,0,1,0,    1,4,32'h0000_a4a4,1});
        vt.push_back('{0, 0,0,  1,4,32'h0000_a4a4,1,5,32'h0000_5b5b,0,  1,1,0,0,    1,5,32'h0000_5b5b,1});
        vt.push_back('{1, 1,15, 0,0,0,            0,0,0,            0,  1,0,0,0,    0,0,0,            0});
        vt.push_back('{0, 1,15, 0,0,0,            0,0,0,            0,  1,0,0,0,    0,0,0,            0});
        vt.push_back('{0, 1,15, 0,0,0,            0,0,0,            0,  1,0,0,0,    0,0,0,            0});
        vt.push_back('{0, 0,15, 0,0,0,            0,0,0,            0,  0,0,0,0,    0,0,0,            0});
        vt.push_back('{0, 0,14, 0,0,0,            0,0,0,            0,  1,0,0,0,    0,0,0,            0});
        vt.push_back('{0, 0,15, 1,15,32'h15,      0,0,0,            0,  0,1,0,0,    0,0,0,            0});
        vt.push_back('{0, 0,15, 0,0,0,            0,0,0,            0,  0,0,0,0,    1,15,32'h15,      0});
        vt.push_back('{0, 0,15, 0,0,0,            0,0,0,            0,  1,0,0,0,    0,15,32'h15,      0});
        vt.push_back('{1, 1,2,  0,0,0,            0,0,0,            2,  1,0,0,0,    0,0,0,            0});
        vt.push_back('{0, 0,0,  1,2,32'h22,       0,0,0,            2,  1,1,0,1,    0,0,0,            0});
        vt.push_back('{0, 1,2,  0,0,0,            0,0,0,            2,  1,0,0,!BYP, 1,2,32'h22,       0});
        vt.push_back('{0, 0,0,  0,0,0,            0,0,0,            2,  1,0,0,1,    0,2,32'h22,       0});
        vt.push_back('{1, 0,0,  1,7,32'h77,       0,0,0,            0,  1,1,0,0,    0,0,0,            0});
        vt.push_back('{0, 0,0,  0,0,0,            0,0,0,            0,  1,0,0,0,    1,7,32'h77,       0});
        vt.push_back('{0, 0,0,  0,0,0,            0,0,0,            0,  1,0,0,0,    0,7,32'h77,       1});
        vt.push_back('{0, 0,0,  0,0,0,            0,0,0,            0,  1,0,0,0,    0,7,32'h77,       1});
        vt.push_back('{1, 0,0,  0,0,0,            0,0,0,            0,  1,0,0,0,    0,0,0,            0});

        for (int k = 0; k < vt.size(); k++) begin
            v = vt[k];
            if (v.rst) do_reset();
            bus.iss_valid = v.iv; bus.iss_addr = AW'(v.ia);
            bus.alu_valid = v.av; bus.alu_addr = AW'(v.aa); bus.alu_data = v.ad;
            bus.mem_valid = v.mv; bus.mem_addr = AW'(v.ma); bus.mem_data = v.md;
            bus.rs_a = AW'(v.rsa); bus.rs_b = '0;
            @(negedge clk);
            s = $sformatf("tbl[%0d]", k);
            chk({s, " iss_ready"}, bus.iss_ready, v.e_ir);
            chk({s, " alu_ready"}, bus.alu_ready, v.e_ar);
            chk({s, " mem_ready"}, bus.mem_ready, v.e_mr);
            chk({s, " hazard_a"}, bus.hazard_a, v.e_ha);
            chk({s, " wrd"}, bus.wrd, v.e_wrd);
            chk({s, " addr_d"}, bus.addr_d, v.e_addr);
            chk({s, " d"}, bus.d, v.e_d);
            chk({s, " wb_err"}, wb_err, v.e_err);
            model_check();
            model_step();
            @(posedge clk);
            #1;
        end

        // reset asserted while a writeback is about to land
        do_reset();
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd9; bus.rs_a = 5'd9;
        @(posedge clk); #1;
        bus.iss_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd9; bus.alu_data = 32'h99;
        @(negedge clk);
        chk("mid alu_ready", bus.alu_ready, 1);
        chk("mid hazard_a", bus.hazard_a, 1);
        @(posedge clk); #1;
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd9; bus.mem_data = 32'h55;
        #2;
        chk("mid wrd before reset", bus.wrd, 1);
        rst_n = 1'b0;
        #1;
        chk("rst wrd", bus.wrd, 0);
        chk("rst addr_d", bus.addr_d, 0);
        chk("rst d", bus.d, 0);
        chk("rst alu_ready", bus.alu_ready, 0);
        chk("rst mem_ready", bus.mem_ready, 0);
        chk("rst iss_ready", bus.iss_ready, 1);
        chk("rst hazard_a", bus.hazard_a, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst held wrd", bus.wrd, 0);
        chk("rst held alu_ready", bus.alu_ready, 0);
        idle_inputs();
        bus.rs_a = 5'd9;
        @(posedge clk); #1 rst_n = 1'b1;
        m_reset();
        @(negedge clk);
        chk("post rst wrd", bus.wrd, 0);
        chk("post rst d", bus.d, 0);
        chk("post rst hazard_a", bus.hazard_a, 0);
        @(posedge clk); #1;

        // randomized run against the model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            int a, m;
            bus.iss_valid = ($urandom_range(0, 2) != 0);
            bus.iss_addr  = AW'($urandom_range(0, 7));
            a = $urandom_range(0, 7);
            m = $urandom_range(0, 7);
            bus.alu_valid = ($urandom_range(0, 1) == 1) && (m_cnt[a] > 0 || $urandom_range(0, 15) == 0);
            bus.alu_addr  = AW'(a);
            bus.alu_data  = $urandom();
            bus.mem_valid = ($urandom_range(0, 1) == 1) && (m_cnt[m] > 0 || $urandom_range(0, 15) == 0);
            bus.mem_addr  = AW'(m);
            bus.mem_data  = $urandom();
            bus.rs_a      = AW'($urandom_range(0, 7));
            bus.rs_b      = AW'($urandom_range(0, 7));
            cycle();
        end

`ifdef REGFILE_WB_BYPASS_EN
        do_reset();
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd1;
        @(posedge clk); #1;
        bus.iss_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd1; bus.alu_data = 32'h0a78_00d0;
        @(posedge clk); #1;
        bus.alu_valid = 1'b0; bus.rs_a = 5'd1; bus.rs_b = 5'd2;
        @(negedge clk);
        chk("byp wrd", bus.wrd, 1);
        chk("byp fwd_a_valid", fwd_a_valid, 1);
        chk("byp fwd_a", fwd_a, 32'h0a78_00d0);
        chk("byp hazard_a", bus.hazard_a, 0);
        chk("byp fwd_b_valid", fwd_b_valid, 0);
        @(posedge clk); #1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_ctrl.md
REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: write data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: register address width.
REQ-003 SHALL have parameter REGFILE_SIZE, default 32: number of architectural registers.
REQ-004 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have ports iss_valid  input  1 and iss_addr  input  ADDR_WIDTH: instruction issued, will later write iss_addr.
REQ-007 SHALL have port iss_ready  output  1: issue accepted this cycle.
REQ-008 SHALL have ports alu_valid  input  1, alu_addr  input  ADDR_WIDTH, alu_data  input  DATA_WIDTH, alu_ready  output  1: ALU writeback request.
REQ-009 SHALL have ports mem_valid  input  1, mem_addr  input  ADDR_WIDTH, mem_data  input  DATA_WIDTH, mem_ready  output  1: load writeback request.
REQ-010 SHALL have ports wrd  output  1, addr_d  output  ADDR_WIDTH, d  output  DATA_WIDTH: register-file write port.
REQ-011 SHALL have ports rs_a, rs_b  input  ADDR_WIDTH and hazard_a, hazard_b  output  1: read-operand hazard query.
REQ-012 SHALL have sticky error output wb_err  output  1.

Function
REQ-013 SHALL transfer a writeback when src_valid and src_ready are both 1 on a rising edge.
REQ-014 SHALL assert at most one of alu_ready/mem_ready per cycle; ready only when that source is granted, combinational from valids and the round-robin pointer.
REQ-015 SHALL grant the sole valid source; with both valid, grant the pointer's source, then point to the other source.
REQ-016 SHALL drive wrd=1, addr_d/d = transferred addr/data exactly one cycle after transfer; otherwise wrd=0 with addr_d/d holding.
REQ-017 SHALL keep a 2-bit pending counter per register.
REQ-018 SHALL set iss_ready = (counter[iss_addr] != 3); issue occurs when iss_valid and iss_ready.
REQ-019 SHALL increment counter[iss_addr] on issue and decrement counter[addr_d] on a cycle with wrd=1.
REQ-020 SHALL leave the counter unchanged when issue and retire hit the same register in one cycle.
REQ-021 SHALL, on retire with counter already 0, keep it at 0 and set wb_err until reset.
REQ-022 SHALL drive hazard_x = (counter[rs_x] != 0), combinational.
REQ-023 SHALL accept writebacks regardless of counter state; no back-pressure from the write port.

Reset
REQ-024 SHALL on rst_n=0 asynchronously clear all counters, wrd=0, addr_d=0, d=0, wb_err=0, pointer to mem.
REQ-025 SHALL drop any writeback in flight when reset asserts mid-operation; the dropped write never reaches the register file.
REQ-026 SHALL drive alu_ready, mem_ready, hazard_a, hazard_b = 0 and iss_ready = 1 while in reset.

Configuration
REQ-027 SHALL with REGFILE_WB_BYPASS_EN defined add outputs fwd_a_valid/fwd_b_valid (1) and fwd_a/fwd_b (DATA_WIDTH).
REQ-028 SHALL with the macro set fwd_x_valid = wrd and addr_d==rs_x and counter[rs_x]==1, fwd_x = d, and force hazard_x=0 when fwd_x_valid.
REQ-029 SHALL without the macro omit the fwd ports; hazard_x per REQ-022 only.

Structure
REQ-030 SHALL place DATA_WIDTH/ADDR_WIDTH/REGFILE_SIZE defaults and the writeback source encoding (SRC_ALU, SRC_MEM) in shared package regfile_pkg.
REQ-031 SHALL implement grant and pointer logic in sub-module wb_rr_arbiter (2 requesters).

Verification
REQ-032 SHALL test: issue r3, alu_valid addr=3 data=0x0960_1050 -> alu_ready=1, next cycle wrd=1 addr_d=3 d=0x0960_1050, hazard on r3 clears the cycle after.
REQ-033 SHALL test: alu and mem valid for 4 cycles after reset -> grants mem,alu,mem,alu; one wrd per cycle.
REQ-034 SHALL test: issue r15 three times -> iss_ready=0 for r15, iss_ready=1 for r14; one r15 retire -> iss_ready=1 again.
REQ-035 SHALL test: issue r2 and retire r2 (counter=1) in the same cycle -> counter stays 1, hazard_a (rs_a=2) stays 1.
REQ-036 SHALL test: retire r7 with counter 0 -> wb_err=1, held until rst_n=0.
REQ-037 SHALL test with REGFILE_WB_BYPASS_EN: counter[r1]=1, wrd=1 addr_d=1 d=0x0a78_00d0, rs_a=1 -> fwd_a_valid=1, fwd_a=0x0a78_00d0, hazard_a=0.
